cpc_host_memcycle: RTL

Host-side bus initiator for the CPC 50-way expansion connector. It generates Z80-style memory read and write cycles and the host's ROMEN_B/RAMRD_B qualifiers. It samples ROMDIS, RAMDIS and READY from expansion boards and returns read data with a source tag. It is used as the CPC-end model and bench driver for expansion boards such as the low-ROM board, and as the core of an FPGA CPC-host emulator.

---
 rtl/cpc_host_memcycle_pkg.sv | 22 ++
 rtl/cpc_host_memcycle_if.sv | 40 ++++
 rtl/cpc_host_memcycle_rom_select.sv | 17 +
 rtl/cpc_host_memcycle.sv | 139 +++++++++++++
 4 files changed

// File: rtl/cpc_host_memcycle_pkg.sv
// Shared types and constants for the CPC expansion-bus host cycle generator.
package cpc_bus_pkg;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_T1   = 3'd1,
    ST_T2   = 3'd2,
    ST_TW   = 3'd3,
    ST_T3   = 3'd4
  } cpc_state_e;

  localparam logic [1:0] SRC_RAM = 2'd0;
  localparam logic [1:0] SRC_ROM = 2'd1;
  localparam logic [1:0] SRC_EXP = 2'd2;
  localparam logic [1:0] SRC_TMO = 2'd3;

  localparam logic [1:0] LROM_REGION = 2'b00;
  localparam logic [1:0] UROM_REGION = 2'b11;

  localparam logic [7:0] RD_TIMEOUT_DATA = 8'hFF;

endpackage

// File: rtl/cpc_host_memcycle_if.sv
// Request/response and 50-way connector signals of the host cycle generator.
interface cpc_host_memcycle_if;
  logic        req;
  logic        req_wr;
  logic [15:0] req_addr;
  logic [7:0]  req_wdata;
  logic        lrom_en;
  logic        urom_en;
  logic        busy;
  logic        ack;
  logic        timeout;
  logic [7:0]  rdata;
  logic [1:0]  rsrc;
  logic [15:0] A;
  logic [7:0]  D_OUT;
  logic        D_OE;
  logic [7:0]  D_IN;
  logic        MREQ_B;
  logic        RD_B;
  logic        WR_B;
  logic        ROMEN_B;
  logic        RAMRD_B;
  logic        ROMDIS;
  logic        RAMDIS;
  logic        READY;

  modport master (
    input  req, req_wr, req_addr, req_wdata, lrom_en, urom_en,
    input  D_IN, ROMDIS, RAMDIS, READY,
    output busy, ack, timeout, rdata, rsrc,
    output A, D_OUT, D_OE, MREQ_B, RD_B, WR_B, ROMEN_B, RAMRD_B
  );

  modport slave (
    output req, req_wr, req_addr, req_wdata, lrom_en, urom_en,
    output D_IN, ROMDIS, RAMDIS, READY,
    input  busy, ack, timeout, rdata, rsrc,
    input  A, D_OUT, D_OE, MREQ_B, RD_B, WR_B, ROMEN_B, RAMRD_B
  );
endinterface

// File: rtl/cpc_host_memcycle_rom_select.sv
// Host ROM-vs-RAM read qualifier decode; writes never select either.
module cpc_rom_select
  import cpc_bus_pkg::*;
(
  input  logic [1:0] region,
  input  logic       lrom_en,
  input  logic       urom_en,
  input  logic       wr,
  output logic       rom_sel,
  output logic       ram_sel
);
  logic hit;

  assign hit     = (region == LROM_REGION && lrom_en) || (region == UROM_REGION && urom_en);
  assign rom_sel = hit & ~wr;
  assign ram_sel = ~hit & ~wr;
endmodule

// File: rtl/cpc_host_memcycle.sv
// Z80-style memory cycle initiator for the CPC expansion connector.
module cpc_host_memcycle
  import cpc_bus_pkg::*;
#(
  parameter int MAX_WAIT = 15,
  parameter int WAIT_W   = 4
) (
  input logic                  CLK,
  input logic                  RESET,
  cpc_host_memcycle_if.master  bus
);
  localparam logic [2:0] S_IDLE = ST_IDLE;
  localparam logic [2:0] S_T1   = ST_T1;
  localparam logic [2:0] S_T2   = ST_T2;
  localparam logic [2:0] S_TW   = ST_TW;
  localparam logic [2:0] S_T3   = ST_T3;

  logic [2:0]        state;
  logic [WAIT_W-1:0] wcnt;
  logic              cap_wr, cap_rom, abort;
  logic              rom_sel, ram_sel;

  logic              busy_q, ack_q, timeout_q, d_oe_q;
  logic [7:0]        rdata_q, d_out_q;
  logic [1:0]        rsrc_q;
  logic [15:0]       a_q;
  logic              mreq_b_q, rd_b_q, wr_b_q, romen_b_q, ramrd_b_q;

  cpc_rom_select u_rom_select (
    .region  (bus.req_addr[15:14]),
    .lrom_en (bus.lrom_en),
    .urom_en (bus.urom_en),
    .wr      (bus.req_wr),
    .rom_sel (rom_sel),
    .ram_sel (ram_sel)
  );

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state     <= S_IDLE;
      wcnt      <= '0;
      cap_wr    <= 1'b0;
      cap_rom   <= 1'b0;
      abort     <= 1'b0;
      busy_q    <= 1'b0;
      ack_q     <= 1'b0;
      timeout_q <= 1'b0;
      rdata_q   <= 8'h00;
      rsrc_q    <= SRC_RAM;
      a_q       <= 16'h0000;
      d_out_q   <= 8'h00;
      d_oe_q    <= 1'b0;
      mreq_b_q  <= 1'b1;
      rd_b_q    <= 1'b1;
      wr_b_q    <= 1'b1;
      romen_b_q <= 1'b1;
      ramrd_b_q <= 1'b1;
    end else begin
      ack_q     <= 1'b0;
      timeout_q <= 1'b0;
      case (state)
        S_IDLE: begin
          // The IDLE cycle carrying ack is a recovery slot: no accept there.
          if (bus.req && !ack_q) begin
            state     <= S_T1;
            busy_q    <= 1'b1;
            cap_wr    <= bus.req_wr;
            cap_rom   <= rom_sel;
            abort     <= 1'b0;
            a_q       <= bus.req_addr;
            mreq_b_q  <= 1'b0;
            rd_b_q    <= bus.req_wr;
            romen_b_q <= ~rom_sel;
            ramrd_b_q <= ~ram_sel;
            d_oe_q    <= bus.req_wr;
            if (bus.req_wr) d_out_q <= bus.req_wdata;
          end
        end
        S_T1: begin
          state  <= S_T2;
          wr_b_q <= ~cap_wr;
        end
        S_T2: begin
          wcnt  <= '0;
          state <= bus.READY ? S_T3 : S_TW;
        end
        S_TW: begin
          if (bus.READY) begin
            state <= S_T3;
          end else begin
            wcnt <= wcnt + 1'b1;
            if (wcnt == WAIT_W'(MAX_WAIT - 1)) begin
              state <= S_T3;
              abort <= 1'b1;
            end
          end
        end
        S_T3: begin
          state     <= S_IDLE;
          busy_q    <= 1'b0;
          ack_q     <= 1'b1;
          timeout_q <= abort;
          mreq_b_q  <= 1'b1;
          rd_b_q    <= 1'b1;
          wr_b_q    <= 1'b1;
          romen_b_q <= 1'b1;
          ramrd_b_q <= 1'b1;
          d_oe_q    <= 1'b0;
          if (!cap_wr) begin
            if (abort) begin
              rdata_q <= RD_TIMEOUT_DATA;
              rsrc_q  <= SRC_TMO;
            end else begin
              rdata_q <= bus.D_IN;
              // ROM-hit picks which disable line applies when both are high.
              rsrc_q  <= cap_rom ? (bus.ROMDIS ? SRC_EXP : SRC_ROM)
                                 : (bus.RAMDIS ? SRC_EXP : SRC_RAM);
            end
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  assign bus.busy    = busy_q;
  assign bus.ack     = ack_q;
  assign bus.timeout = timeout_q;
  assign bus.rdata   = rdata_q;
  assign bus.rsrc    = rsrc_q;
  assign bus.A       = a_q;
  assign bus.D_OUT   = d_out_q;
  assign bus.D_OE    = d_oe_q;
  assign bus.MREQ_B  = mreq_b_q;
  assign bus.RD_B    = rd_b_q;
  assign bus.WR_B    = wr_b_q;
  assign bus.ROMEN_B = romen_b_q;
  assign bus.RAMRD_B = ramrd_b_q;
endmodule
